// File: rtl/layer4_input_arbiter.sv
// Two-requester frame arbiter in front of the SVM layer: grants whole feature frames,
// remembers who was granted in a tag FIFO and routes each returned label back to its owner.
module layer4_input_arbiter #(
  parameter int BEATS_PER_FRAME = 8,
  parameter int TAG_DEPTH       = 4
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [127:0]                 s0_Data_TDATA,
  input  logic                         s0_Data_TVALID,
  output logic                         s0_Data_TREADY,
  input  logic [127:0]                 s1_Data_TDATA,
  input  logic                         s1_Data_TVALID,
  output logic                         s1_Data_TREADY,
  output logic [127:0]                 a_Data_TDATA,
  output logic                         a_Data_TVALID,
  input  logic                         a_Data_TREADY,
  input  logic [7:0]                   pre_label_TDATA,
  input  logic                         pre_label_TVALID,
  output logic                         pre_label_TREADY,
  output logic [7:0]                   label0_TDATA,
  output logic                         label0_TVALID,
  input  logic                         label0_TREADY,
  output logic [7:0]                   label1_TDATA,
  output logic                         label1_TVALID,
  input  logic                         label1_TREADY,
  output logic [$clog2(TAG_DEPTH):0]   in_flight
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(TAG_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_FRAME - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t             state;
  logic               last_grant;
  logic [CNT_W-1:0]   beat_cnt;
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               grant_sel;
  logic               push;
  logic               pop;
  logic               head_tag;
  logic               beat_fire;

  assign fifo_full  = (in_flight == FULL_CNT);
  assign fifo_empty = (in_flight == '0);

  // Requester 1 wins when it is alone, or when both ask and requester 0 was served last.
  assign grant_sel = s1_Data_TVALID & (~s0_Data_TVALID | ~last_grant);
  assign push      = (state == IDLE) & ~fifo_full & (s0_Data_TVALID | s1_Data_TVALID);

  assign head_tag         = tag_mem[rd_ptr];
  assign pre_label_TREADY = ~fifo_empty & (head_tag ? label1_TREADY : label0_TREADY);
  assign pop              = pre_label_TVALID & pre_label_TREADY;
  assign label0_TDATA     = pre_label_TDATA;
  assign label1_TDATA     = pre_label_TDATA;
  assign label0_TVALID    = pre_label_TVALID & ~fifo_empty & ~head_tag;
  assign label1_TVALID    = pre_label_TVALID & ~fifo_empty &  head_tag;

  always_comb begin
    a_Data_TDATA   = '0;
    a_Data_TVALID  = 1'b0;
    s0_Data_TREADY = 1'b0;
    s1_Data_TREADY = 1'b0;
    case (state)
      GRANT0: begin
        a_Data_TDATA   = s0_Data_TDATA;
        a_Data_TVALID  = s0_Data_TVALID;
        s0_Data_TREADY = a_Data_TREADY;
      end
      GRANT1: begin
        a_Data_TDATA   = s1_Data_TDATA;
        a_Data_TVALID  = s1_Data_TVALID;
        s1_Data_TREADY = a_Data_TREADY;
      end
      default: ;
    endcase
  end

  assign beat_fire = a_Data_TVALID & a_Data_TREADY;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            state      <= grant_sel ? GRANT1 : GRANT0;
            last_grant <= grant_sel;
          end
        end
        GRANT0, GRANT1: begin
          // The grant is held through TVALID gaps until the last beat of the frame.
          if (beat_fire) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_flight <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   in_flight <= in_flight + (PTR_W + 1)'(1);
        2'b01:   in_flight <= in_flight - (PTR_W + 1)'(1);
        default: ;
      endcase
    end
  end

  // Tag storage is only meaningful behind the pointers, so it carries no reset.
  always_ff @(posedge ap_clk) begin
    if (push) tag_mem[wr_ptr] <= grant_sel;
  end

endmodule

// File: tb/tb_layer4_input_arbiter.sv
// Bench for layer4_input_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based frame/tag reference model.
module tb_layer4_input_arbiter;

  localparam int BEATS = 8;
  localparam int DEPTH = 4;

  logic         ap_clk = 1'b0;
  logic         ap_rst;
  logic [127:0] s0_Data_TDATA, s1_Data_TDATA;
  logic         s0_Data_TVALID, s1_Data_TVALID;
  wire          s0_Data_TREADY, s1_Data_TREADY;
  wire  [127:0] a_Data_TDATA;
  wire          a_Data_TVALID;
  logic         a_Data_TREADY;
  logic [7:0]   pre_label_TDATA;
  logic         pre_label_TVALID;
  wire          pre_label_TREADY;
  wire  [7:0]   label0_TDATA, label1_TDATA;
  wire          label0_TVALID, label1_TVALID;
  logic         label0_TREADY, label1_TREADY;
  wire  [2:0]   in_flight;

  int n_tests = 0;
  int n_fail  = 0;

  layer4_input_arbiter #(.BEATS_PER_FRAME(BEATS), .TAG_DEPTH(DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s0_Data_TDATA(s0_Data_TDATA), .s0_Data_TVALID(s0_Data_TVALID), .s0_Data_TREADY(s0_Data_TREADY),
    .s1_Data_TDATA(s1_Data_TDATA), .s1_Data_TVALID(s1_Data_TVALID), .s1_Data_TREADY(s1_Data_TREADY),
    .a_Data_TDATA(a_Data_TDATA), .a_Data_TVALID(a_Data_TVALID), .a_Data_TREADY(a_Data_TREADY),
    .pre_label_TDATA(pre_label_TDATA), .pre_label_TVALID(pre_label_TVALID),
    .pre_label_TREADY(pre_label_TREADY),
    .label0_TDATA(label0_TDATA), .label0_TVALID(label0_TVALID), .label0_TREADY(label0_TREADY),
    .label1_TDATA(label1_TDATA), .label1_TVALID(label1_TVALID), .label1_TREADY(label1_TREADY),
    .in_flight(in_flight)
  );

  always #5 ap_clk = ~ap_clk;

  wire [8:0] ctl_act = {a_Data_TVALID, s0_Data_TREADY, s1_Data_TREADY, pre_label_TREADY,
                        label0_TVALID, label1_TVALID, in_flight};

  // Reference model: who owns the output (-1 none), beats sent, last winner, tags awaiting labels.
  int m_owner, m_beats, m_last;
  int m_tags[$];
  logic [127:0] e_adata;
  logic e_avalid, e_s0r, e_s1r, e_prer, e_l0v, e_l1v;
  int   e_inflight;

  function automatic void model_reset();
    m_owner = -1; m_beats = 0; m_last = 1;
    m_tags.delete();
  endfunction

  function automatic void model_eval();
    e_avalid = 1'b0; e_adata = '0; e_s0r = 1'b0; e_s1r = 1'b0;
    e_prer = 1'b0; e_l0v = 1'b0; e_l1v = 1'b0;
    if (m_owner == 0) begin
      e_avalid = s0_Data_TVALID; e_adata = s0_Data_TDATA; e_s0r = a_Data_TREADY;
    end else if (m_owner == 1) begin
      e_avalid = s1_Data_TVALID; e_adata = s1_Data_TDATA; e_s1r = a_Data_TREADY;
    end
    if (m_tags.size() > 0) begin
      if (m_tags[0] == 0) begin e_l0v = pre_label_TVALID; e_prer = label0_TREADY; end
      else                begin e_l1v = pre_label_TVALID; e_prer = label1_TREADY; end
    end
    e_inflight = m_tags.size();
  endfunction

  function automatic logic [8:0] exp_ctl();
    return {e_avalid, e_s0r, e_s1r, e_prer, e_l0v, e_l1v, 3'(e_inflight)};
  endfunction

  function automatic void model_update();
    bit do_pop, do_push;
    int g;
    do_pop = 0; do_push = 0; g = 0;
    if (m_tags.size() > 0)
      do_pop = pre_label_TVALID && ((m_tags[0] == 0) ? label0_TREADY : label1_TREADY);
    if (m_owner < 0) begin
      if (m_tags.size() < DEPTH && (s0_Data_TVALID || s1_Data_TVALID)) begin
        g = (s0_Data_TVALID && s1_Data_TVALID) ? 1 - m_last : (s1_Data_TVALID ? 1 : 0);
        m_owner = g; m_last = g; m_beats = 0; do_push = 1;
      end
    end else if (((m_owner == 0) ? s0_Data_TVALID : s1_Data_TVALID) && a_Data_TREADY) begin
      m_beats++;
      if (m_beats == BEATS) m_owner = -1;
    end
    if (do_pop) void'(m_tags.pop_front());
    if (do_push) m_tags.push_back(g);
  endfunction

  task automatic tick();
    if (ap_rst) model_reset(); else model_update();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_Data_TDATA = '0; s1_Data_TDATA = '0; s0_Data_TVALID = 0; s1_Data_TVALID = 0;
    a_Data_TREADY = 0; pre_label_TDATA = '0; pre_label_TVALID = 0;
    label0_TREADY = 0; label1_TREADY = 0;
  endtask

  task automatic do_reset();
    ap_rst = 1; idle_inputs(); model_reset();
    tick(); tick();
    ap_rst = 0;
  endtask

  task automatic test_reset();
    ap_rst = 1; model_reset();
    s0_Data_TVALID = 1; s1_Data_TVALID = 1; a_Data_TREADY = 1;
    s0_Data_TDATA = {4{32'hDEADBEEF}}; s1_Data_TDATA = {4{32'h12345678}};
    pre_label_TVALID = 1; pre_label_TDATA = 8'h5A; label0_TREADY = 1; label1_TREADY = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (ctl_act !== 9'h000) begin
        n_fail++; $display("FAIL reset_ctl cycle %0d: got %h expected 000", c, ctl_act);
      end
      n_tests++;
      if (a_Data_TDATA !== 128'h0) begin
        n_fail++; $display("FAIL reset_adata cycle %0d: got %h expected 0", c, a_Data_TDATA);
      end
      tick();
    end
    ap_rst = 0; idle_inputs();
  endtask

  task automatic test_contention();
    int seq[$];
    int b0 = 0, b1 = 0, want;
    do_reset();
    a_Data_TREADY = 1;
    for (int c = 0; c < 18; c++) begin
      s0_Data_TVALID = (b0 < BEATS); s1_Data_TVALID = (b1 < BEATS);
      s0_Data_TDATA = {64'hA0, 64'(b0)}; s1_Data_TDATA = {64'hB1, 64'(b1)};
      #1; model_eval();
      n_tests++;
      if (ctl_act !== exp_ctl()) begin
        n_fail++; $display("FAIL contention_ctl cycle %0d: got %h expected %h", c, ctl_act, exp_ctl());
      end
      n_tests++;
      if (a_Data_TDATA !== e_adata) begin
        n_fail++; $display("FAIL contention_data cycle %0d: got %h expected %h", c, a_Data_TDATA, e_adata);
      end
      if (a_Data_TVALID && a_Data_TREADY) begin
        if (s0_Data_TREADY) begin seq.push_back(0); b0++; end
        else begin seq.push_back(1); b1++; end
      end else seq.push_back(2);
      tick();
    end
    // s0 for cycles 1..8, one IDLE cycle (9), then s1 for 10..17; 2 = no transfer
    for (int c = 0; c < 18; c++) begin
      want = (c == 0 || c == 9) ? 2 : ((c < 9) ? 0 : 1);
      n_tests++;
      if (seq[c] !== want) begin
        n_fail++; $display("FAIL contention_order cycle %0d: got %0d expected %0d", c, seq[c], want);
      end
    end
    s0_Data_TVALID = 0; s1_Data_TVALID = 0; #1;
    n_tests++;
    if (in_flight !== 3'd2) begin
      n_fail++; $display("FAIL contention_in_flight: got %0d expected 2", in_flight);
    end
  endtask

  task automatic test_back_to_back();
    int got[$];
    int k = 0, c = 0, s0r_seen = 0;
    do_reset();
    while (k < 24 && c < 120) begin
      s1_Data_TVALID = 1; s1_Data_TDATA = 128'(k); s0_Data_TVALID = 1'b0;
      s0_Data_TDATA = 128'($urandom);
      a_Data_TREADY = (c % 2 == 0);
      #1; model_eval();
      n_tests++;
      if (ctl_act !== exp_ctl()) begin
        n_fail++; $display("FAIL b2b_ctl cycle %0d: got %h expected %h", c, ctl_act, exp_ctl());
      end
      if (s0_Data_TREADY) s0r_seen++;
      if (a_Data_TVALID && a_Data_TREADY) begin got.push_back(int'(a_Data_TDATA[31:0])); k++; end
      tick(); c++;
    end
    s1_Data_TVALID = 0; a_Data_TREADY = 0; #1;
    n_tests++;
    if (got.size() !== 24) begin
      n_fail++; $display("FAIL b2b_beats: got %0d expected 24", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== i) begin
        n_fail++; $display("FAIL b2b_order beat %0d: got %0d expected %0d", i, got[i], i);
      end
    end
    n_tests++;
    if (in_flight !== 3'd3) begin
      n_fail++; $display("FAIL b2b_in_flight: got %0d expected 3", in_flight);
    end
    n_tests++;
    if (s0r_seen !== 0) begin
      n_fail++; $display("FAIL b2b_s0_ready: got %0d cycles high expected 0", s0r_seen);
    end
  endtask

  task automatic test_fifo_full();
    int hs = 0;
    do_reset();
    a_Data_TREADY = 1;
    for (int c = 0; c < 40; c++) begin
      s0_Data_TVALID = 1; s0_Data_TDATA = {$urandom, $urandom, $urandom, $urandom};
      #1; model_eval();
      n_tests++;
      if (ctl_act !== exp_ctl()) begin
        n_fail++; $display("FAIL full_ctl cycle %0d: got %h expected %h", c, ctl_act, exp_ctl());
      end
      if (c >= 36) begin
        n_tests++;
        if ({s0_Data_TREADY, a_Data_TVALID, in_flight} !== {2'b00, 3'd4}) begin
          n_fail++; $display("FAIL full_blocked cycle %0d: got %b/%b/%0d expected 0/0/4",
                             c, s0_Data_TREADY, a_Data_TVALID, in_flight);
        end
      end
      if (a_Data_TVALID && a_Data_TREADY) hs++;
      tick();
    end
    n_tests++;
    if (hs !== 32) begin
      n_fail++; $display("FAIL full_beats: got %0d expected 32", hs);
    end
    pre_label_TDATA = 8'h05; pre_label_TVALID = 1; label0_TREADY = 1;
    #1; model_eval();
    n_tests++;
    if ({pre_label_TREADY, label0_TVALID, label1_TVALID, label0_TDATA} !== {3'b110, 8'h05}) begin
      n_fail++; $display("FAIL full_pop: got %b%b%b %h expected 110 05",
                         pre_label_TREADY, label0_TVALID, label1_TVALID, label0_TDATA);
    end
    tick();
    pre_label_TVALID = 0; label0_TREADY = 0;
    #1; model_eval();
    n_tests++;
    if (ctl_act !== exp_ctl()) begin
      n_fail++; $display("FAIL full_regrant_idle: got %h expected %h", ctl_act, exp_ctl());
    end
    tick();
    #1; model_eval();
    n_tests++;
    if ({s0_Data_TREADY, in_flight} !== {1'b1, 3'd4}) begin
      n_fail++; $display("FAIL full_regrant: got %b/%0d expected 1/4", s0_Data_TREADY, in_flight);
    end
    s0_Data_TVALID = 0;
  endtask

  task automatic test_label_routing();
    int hs = 0;
    do_reset();
    a_Data_TREADY = 1;
    for (int c = 0; c < 32; c++) begin
      s0_Data_TVALID = (hs < 24); s1_Data_TVALID = (hs < 24);
      s0_Data_TDATA = 128'(c); s1_Data_TDATA = 128'(c + 1000);
      #1; model_eval();
      n_tests++;
      if (ctl_act !== exp_ctl()) begin
        n_fail++; $display("FAIL route_ctl cycle %0d: got %h expected %h", c, ctl_act, exp_ctl());
      end
      if (a_Data_TVALID && a_Data_TREADY) hs++;
      tick();
    end
    pre_label_TDATA = 8'h03; pre_label_TVALID = 1; label0_TREADY = 1; label1_TREADY = 0;
    #1;
    n_tests++;
    if ({label0_TVALID, label1_TVALID, pre_label_TREADY, label0_TDATA} !== {3'b101, 8'h03}) begin
      n_fail++; $display("FAIL route_first: got %b%b%b %h expected 101 03",
                         label0_TVALID, label1_TVALID, pre_label_TREADY, label0_TDATA);
    end
    tick();
    pre_label_TDATA = 8'h07;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if ({label0_TVALID, label1_TVALID, pre_label_TREADY} !== 3'b010) begin
        n_fail++; $display("FAIL route_stall cycle %0d: got %b%b%b expected 010",
                           c, label0_TVALID, label1_TVALID, pre_label_TREADY);
      end
      tick();
    end
    label1_TREADY = 1;
    #1;
    n_tests++;
    if ({label0_TVALID, label1_TVALID, pre_label_TREADY, label1_TDATA} !== {3'b011, 8'h07}) begin
      n_fail++; $display("FAIL route_second: got %b%b%b %h expected 011 07",
                         label0_TVALID, label1_TVALID, pre_label_TREADY, label1_TDATA);
    end
    tick();
    pre_label_TDATA = 8'h09; label1_TREADY = 0;
    #1;
    n_tests++;
    if ({label0_TVALID, label1_TVALID, pre_label_TREADY, label0_TDATA} !== {3'b101, 8'h09}) begin
      n_fail++; $display("FAIL route_third: got %b%b%b %h expected 101 09",
                         label0_TVALID, label1_TVALID, pre_label_TREADY, label0_TDATA);
    end
    tick();
    pre_label_TVALID = 0; #1;
    n_tests++;
    if (in_flight !== 3'd0) begin
      n_fail++; $display("FAIL route_drained: got %0d expected 0", in_flight);
    end
  endtask

  task automatic test_reset_mid();
    int hs = 0, c = 0;
    do_reset();
    a_Data_TREADY = 1;
    while (hs < BEATS + 5 && c < 40) begin
      s0_Data_TVALID = 1; s0_Data_TDATA = {64'hC0, 64'(hs)};
      #1;
      if (a_Data_TVALID && a_Data_TREADY) hs++;
      tick(); c++;
    end
    #1;
    n_tests++;
    if (in_flight !== 3'd2) begin
      n_fail++; $display("FAIL midrst_pending: got %0d expected 2", in_flight);
    end
    ap_rst = 1; model_reset();
    s1_Data_TVALID = 1; pre_label_TVALID = 1; label0_TREADY = 1; label1_TREADY = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++;
      if ({ctl_act, a_Data_TDATA} !== {9'h000, 128'h0}) begin
        n_fail++; $display("FAIL midrst_outputs cycle %0d: got %h/%h expected 000/0", k, ctl_act, a_Data_TDATA);
      end
      tick();
    end
    ap_rst = 0; pre_label_TVALID = 0;
    s0_Data_TDATA = {64'hD0, 64'd0}; s1_Data_TDATA = {64'hE1, 64'd0};
    #1; model_eval();
    n_tests++;
    if (ctl_act !== exp_ctl()) begin
      n_fail++; $display("FAIL midrst_idle: got %h expected %h", ctl_act, exp_ctl());
    end
    tick();
    #1;
    n_tests++;
    if ({s0_Data_TREADY, s1_Data_TREADY, a_Data_TDATA} !== {2'b10, 64'hD0, 64'd0}) begin
      n_fail++; $display("FAIL midrst_restart: got %b%b %h expected 10 %h",
                         s0_Data_TREADY, s1_Data_TREADY, a_Data_TDATA, {64'hD0, 64'd0});
    end
    tick();
    s0_Data_TVALID = 0; s1_Data_TVALID = 0;
  endtask

  task automatic test_stray_label();
    do_reset();
    pre_label_TVALID = 1; label0_TREADY = 1; label1_TREADY = 1;
    for (int c = 0; c < 10; c++) begin
      pre_label_TDATA = 8'($urandom);
      #1;
      n_tests++;
      if ({pre_label_TREADY, label0_TVALID, label1_TVALID} !== 3'b000) begin
        n_fail++; $display("FAIL stray_label cycle %0d: got %b%b%b expected 000",
                           c, pre_label_TREADY, label0_TVALID, label1_TVALID);
      end
      tick();
    end
    pre_label_TVALID = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      s0_Data_TVALID = ($urandom % 4) != 0; s1_Data_TVALID = ($urandom % 3) != 0;
      s0_Data_TDATA = {$urandom, $urandom, $urandom, $urandom};
      s1_Data_TDATA = {$urandom, $urandom, $urandom, $urandom};
      a_Data_TREADY = ($urandom % 3) != 0;
      pre_label_TVALID = ($urandom % 2) != 0; pre_label_TDATA = 8'($urandom);
      label0_TREADY = ($urandom % 3) != 0; label1_TREADY = ($urandom % 2) != 0;
      #1; model_eval();
      n_tests++;
      if (ctl_act !== exp_ctl()) begin
        n_fail++; $display("FAIL random_ctl cycle %0d: got %h expected %h", c, ctl_act, exp_ctl());
      end
      n_tests++;
      if (a_Data_TDATA !== e_adata) begin
        n_fail++; $display("FAIL random_data cycle %0d: got %h expected %h", c, a_Data_TDATA, e_adata);
      end
      n_tests++;
      if ({label0_TDATA, label1_TDATA} !== {2{pre_label_TDATA}}) begin
        n_fail++; $display("FAIL random_label_data cycle %0d: got %h/%h expected %h",
                           c, label0_TDATA, label1_TDATA, pre_label_TDATA);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    ap_rst = 1; idle_inputs(); model_reset();
    @(posedge ap_clk); #1;
    test_reset();
    test_contention();
    test_back_to_back();
    test_fifo_full();
    test_label_routing();
    test_reset_mid();
    test_stray_label();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
